// File: rtl/fc_argmax_reader.sv
// Scans the FC2 scores in sram f after fc2_done and reports the signed argmax (lowest index on ties).
// Result pulse arrives WORD_NUM+2 cycles after the start edge; there is no backpressure, and starts while busy are dropped.
module fc_argmax_reader #(
  parameter int DATA_WIDTH             = 8,
  parameter int DATA_NUM_PER_SRAM_ADDR = 4,
  parameter int CLASS_NUM              = 10
) (
  input  logic                                         clk,
  input  logic                                         srstn,
  input  logic                                         fc2_done,
  output logic [9:0]                                   sram_raddr_f,
  input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_f,
  output logic                                         busy,
  output logic                                         predict_valid,
  output logic [3:0]                                   predict_class,
  output logic [DATA_WIDTH-1:0]                        predict_score
);

  localparam int DW       = DATA_WIDTH;
  localparam int DN       = DATA_NUM_PER_SRAM_ADDR;
  localparam int WORD_NUM = (CLASS_NUM + DN - 1) / DN;
  localparam int WCW      = (WORD_NUM > 1) ? $clog2(WORD_NUM) : 1;
  localparam logic [9:0] LAST_ADDR = 10'(WORD_NUM - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [9:0]            raddr_q, raddr_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic signed [DW-1:0]  max_q, max_d;
  logic [3:0]            max_idx_q, max_idx_d;
  logic                  busy_q, busy_d;
  logic                  pvalid_q, pvalid_d;
  logic [3:0]            pclass_q, pclass_d;
  logic [DW-1:0]         pscore_q, pscore_d;

  logic signed [DW-1:0]  lane_val;
  logic [7:0]            base_idx;
  logic [7:0]            lane_idx;
  logic signed [DW-1:0]  word_best_val;
  logic [3:0]            word_best_idx;
  logic signed [DW-1:0]  new_val;
  logic [3:0]            new_idx;

  // Best of the word in index order first, then against the running max.
  always_comb begin
    base_idx      = 8'(word_cnt_q) * 8'(DN);
    lane_val      = sram_rdata_f[(DN-1)*DW +: DW];
    lane_idx      = base_idx;
    word_best_val = lane_val;
    word_best_idx = base_idx[3:0];
    for (int l = 1; l < DN; l++) begin
      lane_val = sram_rdata_f[(DN-1-l)*DW +: DW];
      lane_idx = base_idx + 8'(l);
      if (lane_idx < 8'(CLASS_NUM) && lane_val > word_best_val) begin
        word_best_val = lane_val;
        word_best_idx = lane_idx[3:0];
      end
    end
    if (word_cnt_q == '0 || word_best_val > max_q) begin
      new_val = word_best_val;
      new_idx = word_best_idx;
    end else begin
      new_val = max_q;
      new_idx = max_idx_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    raddr_d    = raddr_q;
    word_cnt_d = word_cnt_q;
    max_d      = max_q;
    max_idx_d  = max_idx_q;
    busy_d     = busy_q;
    pvalid_d   = 1'b0;
    pclass_d   = pclass_q;
    pscore_d   = pscore_q;
    rd_vld_d   = (state_q == READ);

    case (state_q)
      IDLE: begin
        raddr_d = 10'd0;
        busy_d  = 1'b0;
        if (fc2_done) begin
          state_d    = READ;
          busy_d     = 1'b1;
          word_cnt_d = '0;
        end
      end
      READ: begin
        if (raddr_q == LAST_ADDR) begin
          state_d = DRAIN;
          raddr_d = 10'd0;
        end else begin
          raddr_d = raddr_q + 10'd1;
        end
      end
      DRAIN: begin
        state_d  = DONE;
        pvalid_d = 1'b1;
        pclass_d = new_idx;
        pscore_d = new_val;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (rd_vld_q) begin
      max_d      = new_val;
      max_idx_d  = new_idx;
      word_cnt_d = word_cnt_q + WCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q    <= IDLE;
      raddr_q    <= 10'd0;
      rd_vld_q   <= 1'b0;
      word_cnt_q <= '0;
      max_q      <= '0;
      max_idx_q  <= 4'd0;
      busy_q     <= 1'b0;
      pvalid_q   <= 1'b0;
      pclass_q   <= 4'd0;
      pscore_q   <= '0;
    end else begin
      state_q    <= state_d;
      raddr_q    <= raddr_d;
      rd_vld_q   <= rd_vld_d;
      word_cnt_q <= word_cnt_d;
      max_q      <= max_d;
      max_idx_q  <= max_idx_d;
      busy_q     <= busy_d;
      pvalid_q   <= pvalid_d;
      pclass_q   <= pclass_d;
      pscore_q   <= pscore_d;
    end
  end

  assign sram_raddr_f  = raddr_q;
  assign busy          = busy_q;
  assign predict_valid = pvalid_q;
  assign predict_class = pclass_q;
  assign predict_score = pscore_q;

endmodule

// File: tb/tb_fc_argmax_reader.sv
// Bench for fc_argmax_reader: table of score sets with expected argmax, sram f model, result scoreboard.
module tb_fc_argmax_reader;

  logic        clk = 1'b0;
  logic        srstn;
  logic        fc2_done;
  logic [9:0]  sram_raddr_f;
  logic [31:0] sram_rdata_f;
  logic        busy;
  logic        predict_valid;
  logic [3:0]  predict_class;
  logic [7:0]  predict_score;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fc_argmax_reader #(
    .DATA_WIDTH(8),
    .DATA_NUM_PER_SRAM_ADDR(4),
    .CLASS_NUM(10)
  ) dut (
    .clk(clk),
    .srstn(srstn),
    .fc2_done(fc2_done),
    .sram_raddr_f(sram_raddr_f),
    .sram_rdata_f(sram_rdata_f),
    .busy(busy),
    .predict_valid(predict_valid),
    .predict_class(predict_class),
    .predict_score(predict_score)
  );

  typedef struct packed {
    logic [9:0][7:0] sc;
    logic [7:0]      fill;
    int              cls;
    int              score;
    logic            dbl;
  } vec_t;

  typedef struct {
    int cls;
    int score;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [4];
  vec_t        vecs [6];

  // Synchronous-read sram f: data follows the address by one cycle.
  always @(posedge clk)
    sram_rdata_f <= (sram_raddr_f < 10'd3) ? mem[sram_raddr_f[1:0]] : 32'hDEAD_BEEF;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (srstn === 1'b1 && predict_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got pulse with class %0d, expected none at %0t",
                 predict_class, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_class", int'(predict_class), e.cls);
        check("sb_score", int'($signed(predict_score)), e.score);
      end
    end
  end

  function automatic vec_t mk(input int s0, input int s1, input int s2, input int s3,
                              input int s4, input int s5, input int s6, input int s7,
                              input int s8, input int s9, input int fill,
                              input int cls, input int score, input bit dbl);
    vec_t r;
    r.sc[0] = 8'(s0); r.sc[1] = 8'(s1); r.sc[2] = 8'(s2); r.sc[3] = 8'(s3);
    r.sc[4] = 8'(s4); r.sc[5] = 8'(s5); r.sc[6] = 8'(s6); r.sc[7] = 8'(s7);
    r.sc[8] = 8'(s8); r.sc[9] = 8'(s9);
    r.fill  = 8'(fill);
    r.cls   = cls;
    r.score = score;
    r.dbl   = dbl;
    return r;
  endfunction

  task automatic load_mem(input vec_t v);
    for (int w = 0; w < 3; w++) begin
      for (int l = 0; l < 4; l++) begin
        int idx;
        idx = w * 4 + l;
        mem[w][(3-l)*8 +: 8] = (idx < 10) ? v.sc[idx] : v.fill;
      end
    end
    mem[3] = 32'h0;
  endtask

  task automatic run_scan(input vec_t v);
    load_mem(v);
    @(negedge clk);
    fc2_done = 1'b1;
    exp_q.push_back('{v.cls, v.score});
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) fc2_done = 1'b0;
      if (k == 2 && v.dbl) fc2_done = 1'b1;
      if (k == 3) fc2_done = 1'b0;
      if (k <= 3) check("raddr_seq", int'(sram_raddr_f), k - 1);
      check("busy_window", int'(busy), (k <= 5) ? 1 : 0);
      check("valid_timing", int'(predict_valid), (k == 5) ? 1 : 0);
    end
    repeat (3) begin
      @(negedge clk);
      check("hold_class", int'(predict_class), v.cls);
      check("hold_score", int'($signed(predict_score)), v.score);
      check("idle_raddr", int'(sram_raddr_f), 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 32'h0;
    srstn    = 1'b0;
    fc2_done = 1'b0;

    vecs[0] = mk(3, -5, 7, 1, 0, 100, -128, 2, 9, 4, 0, 5, 100, 1'b0);
    vecs[1] = mk(-128, -128, -128, -128, -128, -128, -128, -128, -128, -128, 127, 0, -128, 1'b0);
    vecs[2] = mk(1, 2, 3, 50, 4, 5, 6, 7, 50, 8, 99, 3, 50, 1'b1);
    vecs[3] = mk(0, -1, 5, -7, 20, -3, 126, 10, -100, 127, 0, 9, 127, 1'b0);
    vecs[4] = mk(-1, -2, -3, -4, -5, -6, -7, -8, -9, -10, 0, 0, -1, 1'b0);
    vecs[5] = mk(-10, -20, -30, 40, -50, -60, -70, -80, -90, -100, 127, 3, 40, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    srstn = 1'b1;

    repeat (10) begin
      @(negedge clk);
      check("idle_raddr", int'(sram_raddr_f), 0);
      check("idle_busy", int'(busy), 0);
      check("idle_valid", int'(predict_valid), 0);
      check("idle_class", int'(predict_class), 0);
      check("idle_score", int'(predict_score), 0);
    end

    for (int i = 0; i < 4; i++) run_scan(vecs[i]);

    // Reset in the middle of READ must abort without a result.
    load_mem(vecs[0]);
    @(negedge clk);
    fc2_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fc2_done = 1'b0;
    @(negedge clk);
    srstn = 1'b0;
    @(negedge clk);
    check("rst_raddr", int'(sram_raddr_f), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(predict_valid), 0);
    check("rst_class", int'(predict_class), 0);
    check("rst_score", int'(predict_score), 0);
    srstn = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("post_rst_valid", int'(predict_valid), 0);
      check("post_rst_busy", int'(busy), 0);
    end

    for (int i = 4; i < 6; i++) run_scan(vecs[i]);

    repeat (4) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fc_argmax_reader.md
Name: fc_argmax_reader

Overview:
- Post-FC2 result stage. It consumes the CLASS_NUM signed FC2 scores written into sram f.
- After fc2_done it reads sram f and performs a running signed argmax across all scores.
- It reports the predicted class index and its score with a one-cycle valid pulse.
- It sits directly downstream of the FC controller and owns the sram f read port.

Parameters:
- DATA_WIDTH, 8, bit width of one signed score.
- DATA_NUM_PER_SRAM_ADDR, 4, number of scores packed per sram f word.
- CLASS_NUM, 10, number of scores to scan (1..16).
- WORD_NUM, ceil(CLASS_NUM/DATA_NUM_PER_SRAM_ADDR) = 3, number of sram f words read.

Ports:
- clk  input  1  clock.
- srstn  input  1  reset; synchronous, active-low.
- fc2_done  input  1  one-cycle start pulse from the FC controller.
- sram_raddr_f  output  10  sram f read address.
- sram_rdata_f  input  DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR  sram f read data, valid one cycle after address.
- busy  output  1  high while a scan is in progress.
- predict_valid  output  1  one-cycle pulse when a result is ready.
- predict_class  output  4  index of the maximum score.
- predict_score  output  DATA_WIDTH  signed maximum score.

Behaviour:
- Reset (srstn=0 at posedge):
  - State goes to IDLE.
  - sram_raddr_f, busy, predict_valid, predict_class, predict_score, word/byte counters and running max all clear to 0.
  - A reset mid-scan aborts the scan; no predict_valid is produced.
- Packing:
  - Index i lives at word i/4.
  - Lane i%4 = 0 is bits [31:24], lane 1 is [23:16], lane 2 is [15:8], lane 3 is [7:0] (MSB lane first).
  - Lanes of the last word with index >= CLASS_NUM are ignored (default: word 2, lanes 2 and 3).
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: sram_raddr_f=0. On fc2_done=1 go to READ; the address counter starts at 0.
  - READ: sram_raddr_f = address counter, incremented each cycle. After issuing address WORD_NUM-1, go to DRAIN.
  - DRAIN: one cycle; the last word's data is consumed. Then go to DONE.
  - DONE: one cycle. predict_valid=1 and predict_class/predict_score are already updated. Then go to IDLE.
- Data capture: a registered read-valid flag, delayed one cycle from READ, marks sram_rdata_f as valid. Each valid word updates the running max in that cycle.
- Compare rules:
  - Signed DATA_WIDTH comparison.
  - Lanes are evaluated in index order within the word (combinational chain), then against the running max.
  - Replace only on strictly greater, so ties keep the lowest index.
  - Index 0 is loaded unconditionally as the initial max.
- Latency, with fc2_done sampled at edge E0:
  - Addresses 0, 1, 2 are presented in cycles E0+1, E0+2, E0+3.
  - Data arrives in cycles E0+2, E0+3, E0+4.
  - predict_valid is high in cycle E0+5.
  - Total: WORD_NUM+2 cycles after the start edge.
- busy: high from the cycle after fc2_done through DONE inclusive; low in IDLE.
- fc2_done while busy is ignored (no restart, no queuing).
- fc2_done in DONE is also ignored.
- predict_class/predict_score hold their value until the next scan completes. They are not cleared at scan start.
- Intermediate running-max values are internal and are not visible on predict_* before DONE.
- sram_raddr_f never exceeds WORD_NUM-1.

Test Plan:
- Reset, then idle 10 cycles with fc2_done=0 -> all outputs 0, sram_raddr_f stays 0, busy=0.
- Scores {3,-5,7,1,0,100,-128,2,9,4}, fc2_done pulse -> addresses 0,1,2 on consecutive cycles; predict_valid exactly 5 cycles after the pulse; class=5, score=100.
- All scores -128, with word 2 lanes 2/3 set to 127 (ignored lanes) -> class=0, score=-128.
- Tie: scores 50 at indices 3 and 8, others lower -> class=3, score=50.
- Second fc2_done pulse 2 cycles into a scan -> single predict_valid at the original timing and no address restart. A new scan after return to IDLE, with max at index 9 =127, gives class=9; outputs hold between scans.
- srstn=0 during READ (cycle E0+2) -> next cycle all outputs 0 and state IDLE; no predict_valid. A subsequent fc2_done produces a correct result.
